pc_seq: RTL
===========

// Module: pc_seq
// PURPOSE
//  Sequencer for pc_unit: drives its en/ld_ct/d_r/ld/sync-reset controls each cycle.
//  Arbitrates redirect sources: trap, jump, branch, stall, sequential increment.
//  Sits between decode/execute redirect logic and pc_unit.
//  Owns boot hold-off, one-cycle redirect bubble, misalignment trap and double-fault halt.
// PARAMETERS
//  TRAP_VEC     32'h0000_0100  absolute trap handler address
//  BOOT_CYCLES  4              cycles pc_unit is held in reset after rst_n_i release (>=1)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_n_i        in   1   asynchronous reset, active-low
//  stall_i        in   1   hold PC (fetch backpressure)
//  br_req_i       in   1   relative branch taken
//  br_off_i       in   32  branch offset, two's complement, added to PC
//  jmp_req_i      in   1   absolute jump
//  jmp_tgt_i      in   32  jump target
//  trap_req_i     in   1   external/sw trap request
//  pc_i           in   32  current pc_unit.pc_o
//  pc_aligned_i   in   1   pc_unit.is_aligned_o
//  pc_rst_o       out  1   to pc_unit.rst_i (sync, active-high)
//  pc_en_o        out  1   to pc_unit.en_i
//  pc_ld_ct_o     out  1   to pc_unit.ld_ct_i (1 load, 0 count)
//  pc_d_r_o       out  1   to pc_unit.d_r_i (1 add, 0 replace)
//  pc_ld_o        out  32  to pc_unit.ld_i
//  fetch_vld_o    out  1   pc_i is a valid fetch address this cycle
//  trap_ack_o     out  1   1-cycle pulse: trap vector load issued
//  epc_o          out  32  PC saved at last trap
//  halted_o       out  1   double fault; sticky until reset
// BEHAVIOUR
//  Reset (rst_n_i=0, async): state=BOOT, boot_cnt=0, epc_o=0, halted_o=0, trap_ack_o=0,
//   fetch_vld_o=0, pc_rst_o=1, pc_en_o=0, pc_ld_ct_o=0, pc_d_r_o=0, pc_ld_o=0.
//  pc_* outputs combinational from state+inputs (pc_unit acts same edge); status registered.
//  States: BOOT, RUN, BUBBLE, TRAP, HALT.
//  BOOT: pc_rst_o=1, count; after BOOT_CYCLES edges -> RUN. Requests ignored.
//  RUN: fetch_vld_o = pc_aligned_i & ~stall_i. Priority, highest first:
//   1 misaligned (pc_aligned_i=0): epc<=pc_i, load TRAP_VEC (en=1,ld_ct=1,d_r=0) -> TRAP
//   2 trap_req_i: same as 1 -> TRAP
//   3 jmp_req_i: en=1,ld_ct=1,d_r=0,ld=jmp_tgt_i -> BUBBLE
//   4 br_req_i:  en=1,ld_ct=1,d_r=1,ld=br_off_i -> BUBBLE
//   5 stall_i: en=0, stay RUN
//   6 else: en=1,ld_ct=0 (pc_unit +4), stay RUN
//  Redirects override stall_i; lower-priority requests in the same cycle are dropped.
//  BUBBLE: en=0, fetch_vld_o=0, one cycle -> RUN (requests ignored).
//  TRAP: trap_ack_o=1 this cycle only, en=0, fetch_vld_o=0 -> RUN.
//   First RUN cycle after TRAP with pc_aligned_i=0 (TRAP_VEC misaligned) -> HALT, no epc update.
//  HALT: halted_o=1, en=0, fetch_vld_o=0; exit only via rst_n_i.
//  Branch add wraps mod 2^32 (pc_unit behaviour); no overflow detection.
//  Reset asserted mid-redirect/trap: immediate return to BOOT; pending load abandoned.
//  pc_ld_o = 0 whenever pc_ld_ct_o=0.
// TESTING
//  rst_n_i low then high, BOOT_CYCLES=4 -> pc_rst_o high 4 cycles, then pc_i 0,4,8,C with fetch_vld_o=1.
//  At pc_i=0x10 br_req_i, br_off_i=-8 -> next pc 0x08, one cycle fetch_vld_o=0, then 0x0C.
//  jmp_req_i(0x200)+br_req_i+stall_i same cycle -> pc 0x200, branch dropped, BUBBLE.
//  Jump to 0x202 -> epc_o=0x202, pc=TRAP_VEC, trap_ack_o 1-cycle pulse, resumes 0x100,0x104.
//  TRAP_VEC=32'h102 + trap_req_i -> TRAP then HALT; halted_o=1, pc_i frozen until rst_n_i.
//  stall_i high 3 cycles at pc 0x20 -> pc stays 0x20, fetch_vld_o=0; rst_n_i low mid-stall -> BOOT.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: control sequencer for pc_unit.
// Arbitrates trap/jump/branch/stall redirects, boot hold-off and halt.
module pc_seq #(
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        br_req_i,
  input  logic [31:0] br_off_i,
  input  logic        jmp_req_i,
  input  logic [31:0] jmp_tgt_i,
  input  logic        trap_req_i,
  input  logic [31:0] pc_i,
  input  logic        pc_aligned_i,
  output logic        pc_rst_o,
  output logic        pc_en_o,
  output logic        pc_ld_ct_o,
  output logic        pc_d_r_o,
  output logic [31:0] pc_ld_o,
  output logic        fetch_vld_o,
  output logic        trap_ack_o,
  output logic [31:0] epc_o,
  output logic        halted_o
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_BUBBLE,
    S_TRAP,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [31:0]   epc_q, epc_d;
  logic          post_q, post_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_BOOT;
      boot_q  <= '0;
      epc_q   <= '0;
      post_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      epc_q   <= epc_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    epc_d       = epc_q;
    post_d      = post_q;
    pc_rst_o    = 1'b0;
    pc_en_o     = 1'b0;
    pc_ld_ct_o  = 1'b0;
    pc_d_r_o    = 1'b0;
    pc_ld_o     = '0;
    fetch_vld_o = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        pc_rst_o = 1'b1;
        if (boot_q == BW'(BOOT_CYCLES - 1)) begin
          state_d = S_RUN;
          boot_d  = '0;
        end else begin
          boot_d = boot_q + BW'(1);
        end
      end
      S_RUN: begin
        fetch_vld_o = pc_aligned_i & ~stall_i;
        post_d      = 1'b0;
        // A misaligned trap vector faults again right away: give up.
        if (post_q && !pc_aligned_i) begin
          state_d = S_HALT;
        end else if (!pc_aligned_i || trap_req_i) begin
          epc_d      = pc_i;
          pc_en_o    = 1'b1;
          pc_ld_ct_o = 1'b1;
          pc_ld_o    = TRAP_VEC;
          state_d    = S_TRAP;
        end else if (jmp_req_i) begin
          pc_en_o    = 1'b1;
          pc_ld_ct_o = 1'b1;
          pc_ld_o    = jmp_tgt_i;
          state_d    = S_BUBBLE;
        end else if (br_req_i) begin
          pc_en_o    = 1'b1;
          pc_ld_ct_o = 1'b1;
          pc_d_r_o   = 1'b1;
          pc_ld_o    = br_off_i;
          state_d    = S_BUBBLE;
        end else if (!stall_i) begin
          pc_en_o = 1'b1;
        end
      end
      S_BUBBLE: state_d = S_RUN;
      S_TRAP: begin
        state_d = S_RUN;
        post_d  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  assign trap_ack_o = (state_q == S_TRAP);
  assign halted_o   = (state_q == S_HALT);
  assign epc_o      = epc_q;

endmodule
